// File: rtl/call_scheduler_if.sv
// Call scheduler bus: buttons, elevator status in,
// target floor, pending calls and direction out.
interface call_scheduler_if;
   logic       A_e;
   logic       B_e;
   logic       C_e;
   logic [1:0] EA;
   logic       door;
   logic       alarm;
   logic       B1;
   logic       B0;
   logic [2:0] pending;
   logic [1:0] dir;

   modport master (
      output A_e, B_e, C_e, EA, door, alarm,
      input  B1, B0, pending, dir
   );

   modport slave (
      input  A_e, B_e, C_e, EA, door, alarm,
      output B1, B0, pending, dir
   );
endinterface

// File: rtl/call_scheduler.sv
// Elevator call scheduler: synchronised call capture,
// IDLE/UP/DOWN direction FSM and nearest-floor target.
module call_scheduler (
   input logic             clk,
   input logic             reset,
   call_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dir_t;

   logic [2:0] btn;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] hist;
   logic [2:0] evt;
   logic [2:0] pend;
   logic [2:0] here;
   logic [2:0] clr;
   logic [2:0] avail;
   logic       above;
   logic       below;
   logic       hold;
   dir_t       dir;
   dir_t       dir_nxt;
   logic [1:0] tgt;
   logic [1:0] tgt_nxt;

   assign btn = {bus.C_e, bus.B_e, bus.A_e};
   assign evt = s2 & ~hist;

   // Two-flop synchroniser plus history flop per button
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1   <= 3'b000;
         s2   <= 3'b000;
         hist <= 3'b000;
      end else begin
         s1   <= btn;
         s2   <= s1;
         hist <= s2;
      end
   end

   // One-hot of the current floor, empty when EA is invalid
   always_comb begin
      here = 3'b000;
      unique case (bus.EA)
         2'b00:   here = 3'b001;
         2'b01:   here = 3'b010;
         2'b10:   here = 3'b100;
         default: here = 3'b000;
      endcase
   end

   assign clr   = bus.door ? here : 3'b000;
   assign avail = pend & ~here;
   assign hold  = bus.alarm | (bus.EA == 2'b11);

   assign above = (bus.EA == 2'b00) ? |avail[2:1] :
                  (bus.EA == 2'b01) ? avail[2] :
                  1'b0;
   assign below = (bus.EA == 2'b10) ? |avail[1:0] :
                  (bus.EA == 2'b01) ? avail[0] :
                  1'b0;

   // Pending calls: set on call event, clear on service;
   // clear wins when both land in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= 3'b000;
      end else begin
         pend <= (pend | evt) & ~clr;
      end
   end

   // Direction state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir <= IDLE;
      end else begin
         dir <= dir_nxt;
      end
   end

   // Next direction: keep heading while calls remain ahead
   always_comb begin
      dir_nxt = dir;
      if (!hold) begin
         unique case (dir)
            DOWN: begin
               if (below)      dir_nxt = DOWN;
               else if (above) dir_nxt = UP;
               else            dir_nxt = IDLE;
            end
            default: begin
               if (above)      dir_nxt = UP;
               else if (below) dir_nxt = DOWN;
               else            dir_nxt = IDLE;
            end
         endcase
      end
   end

   // Next target: nearest pending floor in the new direction
   always_comb begin
      tgt_nxt = tgt;
      if (!hold) begin
         unique case (dir_nxt)
            UP: begin
               if (bus.EA == 2'b00 && avail[1])
                  tgt_nxt = 2'b01;
               else
                  tgt_nxt = 2'b10;
            end
            DOWN: begin
               if (bus.EA == 2'b10 && avail[1])
                  tgt_nxt = 2'b01;
               else
                  tgt_nxt = 2'b00;
            end
            default: tgt_nxt = bus.EA;
         endcase
      end
   end

   // Target register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tgt <= 2'b00;
      end else begin
         tgt <= tgt_nxt;
      end
   end

   assign bus.pending = pend;
   assign bus.dir     = dir;
   assign bus.B1      = tgt[1];
   assign bus.B0      = tgt[0];

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: floor-rule model checked
// every cycle plus directed scenario checks.
module tb_call_scheduler;

   logic clk = 1'b0;
   logic reset;

   call_scheduler_if bus ();

   call_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm,
                      input logic [2:0] act,
                      input logic [2:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b want %b",
                  nm, $time, act, exp);
      end
   endtask

   // Model state
   logic [2:0] m_pend = 3'b000;
   logic [1:0] m_dir  = 2'b00;
   logic [1:0] m_tgt  = 2'b00;
   logic [2:0] m_prev = 3'b000;
   logic [2:0] m_r1   = 3'b000;
   logic [2:0] m_r2   = 3'b000;

   always @(negedge reset) begin
      m_pend = 3'b000;
      m_dir  = 2'b00;
      m_tgt  = 2'b00;
      m_prev = 3'b000;
      m_r1   = 3'b000;
      m_r2   = 3'b000;
   end

   // Model: a button rise seen at edge k lands in
   // pending at edge k+2; direction/target by floor rules
   always @(posedge clk) begin
      logic [2:0] b;
      logic [2:0] ev;
      logic [2:0] av;
      logic [2:0] np;
      int ea;
      int na;
      int nb;
      if (reset === 1'b1) begin
         b  = {bus.C_e, bus.B_e, bus.A_e};
         ev = m_r2;
         m_r2 = m_r1;
         m_r1 = b & ~m_prev;
         m_prev = b;
         ea = int'(bus.EA);
         av = m_pend;
         if (ea < 3) av[ea] = 1'b0;
         na = -1;
         for (int f = ea + 1; f < 3; f++)
            if (na < 0 && av[f]) na = f;
         nb = -1;
         for (int f = ea - 1; f >= 0; f--)
            if (nb < 0 && av[f]) nb = f;
         if (!(bus.alarm || ea == 3)) begin
            if (m_dir == 2'b10) begin
               if (nb >= 0)      m_dir = 2'b10;
               else if (na >= 0) m_dir = 2'b01;
               else              m_dir = 2'b00;
            end else begin
               if (na >= 0)      m_dir = 2'b01;
               else if (nb >= 0) m_dir = 2'b10;
               else              m_dir = 2'b00;
            end
            if (m_dir == 2'b01)      m_tgt = 2'(na);
            else if (m_dir == 2'b10) m_tgt = 2'(nb);
            else                     m_tgt = 2'(ea);
         end
         np = m_pend | ev;
         if (bus.door && ea < 3) np[ea] = 1'b0;
         m_pend = np;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("pending", bus.pending, m_pend);
         chk("dir", {1'b0, bus.dir}, {1'b0, m_dir});
         chk("target", {1'b0, bus.B1, bus.B0},
             {1'b0, m_tgt});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string nm,
                      input logic [2:0] p,
                      input logic [1:0] d,
                      input logic [1:0] t);
      chk({nm, ".pending"}, bus.pending, p);
      chk({nm, ".dir"}, {1'b0, bus.dir}, {1'b0, d});
      chk({nm, ".target"}, {1'b0, bus.B1, bus.B0},
          {1'b0, t});
   endtask

   initial begin
      reset     = 1'b0;
      bus.A_e   = 1'b0;
      bus.B_e   = 1'b0;
      bus.C_e   = 1'b0;
      bus.EA    = 2'b00;
      bus.door  = 1'b0;
      bus.alarm = 1'b0;
      cyc(2);
      lit("reset", 3'b000, 2'b00, 2'b00);
      #2 reset = 1'b1;
      cyc(1);

      // single call to C
      bus.C_e = 1'b1;
      cyc(1);
      bus.C_e = 1'b0;
      cyc(1);
      chk("c_edge2", bus.pending, 3'b000);
      cyc(1);
      lit("c_edge3", 3'b100, 2'b00, 2'b00);
      cyc(1);
      lit("c_edge4", 3'b100, 2'b01, 2'b10);

      // service at C
      bus.EA = 2'b10;
      bus.door = 1'b1;
      cyc(1);
      lit("svc_c", 3'b000, 2'b00, 2'b10);
      bus.door = 1'b0;
      bus.EA = 2'b00;
      cyc(1);
      lit("idle_a", 3'b000, 2'b00, 2'b00);

      // nearest first
      bus.B_e = 1'b1;
      bus.C_e = 1'b1;
      cyc(1);
      bus.B_e = 1'b0;
      bus.C_e = 1'b0;
      cyc(2);
      chk("bc_pend", bus.pending, 3'b110);
      cyc(1);
      lit("near_b", 3'b110, 2'b01, 2'b01);
      bus.EA = 2'b01;
      bus.door = 1'b1;
      cyc(1);
      lit("near_c", 3'b100, 2'b01, 2'b10);
      bus.door = 1'b0;

      // alarm-held UP while C serviced, then A call
      bus.alarm = 1'b1;
      bus.EA = 2'b10;
      bus.door = 1'b1;
      cyc(1);
      lit("alm_clr", 3'b000, 2'b01, 2'b10);
      bus.door = 1'b0;
      bus.EA = 2'b01;
      bus.A_e = 1'b1;
      cyc(1);
      bus.A_e = 1'b0;
      cyc(2);
      lit("alm_a", 3'b001, 2'b01, 2'b10);
      bus.alarm = 1'b0;
      cyc(1);
      lit("reverse", 3'b001, 2'b10, 2'b00);

      // held C gives a single event
      bus.C_e = 1'b1;
      cyc(3);
      chk("held_c", bus.pending, 3'b101);
      bus.EA = 2'b10;
      bus.door = 1'b1;
      cyc(1);
      chk("held_clr", bus.pending, 3'b001);
      bus.door = 1'b0;
      cyc(4);
      chk("held_once", bus.pending, 3'b001);
      bus.C_e = 1'b0;

      // clear A, then set up target C
      bus.EA = 2'b00;
      bus.door = 1'b1;
      cyc(1);
      lit("clr_a", 3'b000, 2'b00, 2'b00);
      bus.door = 1'b0;
      bus.C_e = 1'b1;
      cyc(1);
      bus.C_e = 1'b0;
      cyc(3);
      lit("tgt_c", 3'b100, 2'b01, 2'b10);

      // alarm freeze with A call from floor B
      bus.alarm = 1'b1;
      bus.EA = 2'b01;
      bus.A_e = 1'b1;
      cyc(1);
      bus.A_e = 1'b0;
      cyc(2);
      lit("freeze", 3'b101, 2'b01, 2'b10);
      bus.alarm = 1'b0;
      cyc(1);
      lit("unfreeze", 3'b101, 2'b01, 2'b10);

      // set and clear on same edge: clear wins
      bus.EA = 2'b00;
      bus.door = 1'b1;
      bus.A_e = 1'b1;
      cyc(1);
      bus.A_e = 1'b0;
      cyc(3);
      chk("clr_wins", bus.pending, 3'b100);
      bus.door = 1'b0;

      // invalid floor: hold dir/target/clearing
      cyc(1);
      bus.EA = 2'b11;
      bus.door = 1'b1;
      bus.A_e = 1'b1;
      bus.B_e = 1'b1;
      cyc(1);
      bus.A_e = 1'b0;
      bus.B_e = 1'b0;
      cyc(2);
      lit("inv_hold", 3'b111, 2'b01, 2'b10);

      // async reset between edges, A held through it
      bus.A_e = 1'b1;
      #2 reset = 1'b0;
      #1 lit("async_rst", 3'b000, 2'b00, 2'b00);
      cyc(1);
      bus.EA = 2'b01;
      bus.door = 1'b0;
      #2 reset = 1'b1;
      cyc(2);
      chk("rel_pre", bus.pending, 3'b000);
      cyc(1);
      chk("rel_evt", bus.pending, 3'b001);
      cyc(3);
      bus.A_e = 1'b0;
      cyc(2);
      lit("rel_once", 3'b001, 2'b10, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have ports A_e, B_e, C_e, input, 1 bit each: raw, asynchronous, active-high call buttons for floors A, B and C.
REQ-004 The module SHALL have port EA, input, 2 bits: current floor code from the elevator FSM (00=A, 01=B, 10=C, 11=invalid).
REQ-005 The module SHALL have port door, input, 1 bit: door state from the door FSM (1=open).
REQ-006 The module SHALL have port alarm, input, 1 bit: overload alarm from the people FSM (1=active).
REQ-007 The module SHALL have ports B1, B0, output, 1 bit each, registered: target floor code {B1,B0}, same encoding as EA, consumed by the elevator FSM and the door-call logic.
REQ-008 The module SHALL have port pending, output, 3 bits, registered: outstanding calls, bit0=A, bit1=B, bit2=C.
REQ-009 The module SHALL have port dir, output, 2 bits, registered: scheduler state (00=IDLE, 01=UP, 10=DOWN).

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer followed by a history flop; a call event SHALL be stage2 & ~history (rising edge only).
REQ-011 A button held high SHALL produce exactly one call event; a release followed by a press SHALL produce a new event.
REQ-012 On a call event for floor f, pending[f] SHALL be set. Latency: input high before edge k gives pending[f]=1 after edge k+2.
REQ-013 pending[f] SHALL clear on the edge where EA==f and door==1.
REQ-014 If a set and a clear for the same floor occur in the same cycle, clear SHALL win.
REQ-015 The FSM SHALL have states IDLE, UP and DOWN, evaluated every cycle from the registered pending vector (pending-from-edges, excluding the current floor) and EA.
REQ-016 IDLE transitions: any pending above EA goes to UP; else any pending below EA goes to DOWN; else stay in IDLE.
REQ-017 UP transitions: pending above EA stays in UP; else pending below goes to DOWN; else goes to IDLE.
REQ-018 DOWN transitions mirror UP.
REQ-019 The target SHALL be registered one cycle after the state/pending evaluation.
REQ-020 In UP, the target SHALL be the nearest pending floor above EA.
REQ-021 In DOWN, the target SHALL be the nearest pending floor below EA.
REQ-022 In IDLE, the target SHALL equal EA.
REQ-023 While alarm==1, dir and {B1,B0} SHALL hold their values. Call capture (REQ-012) and clearing (REQ-013) SHALL continue.
REQ-024 While EA==11, dir, {B1,B0} and pending-clearing SHALL hold their values. Call capture SHALL continue.
REQ-025 {B1,B0} SHALL never be 11.
REQ-026 The synchronizers SHALL count as 3 flops per button; no combinational path SHALL run from A_e, B_e or C_e to any output.

Reset
REQ-027 On reset==0, asynchronously: pending=000, dir=IDLE, {B1,B0}=00, all synchronizer and history flops=0.
REQ-028 Reset asserted mid-operation SHALL discard all pending calls. A button already held high at reset release SHALL generate one event at its first sampled high after release.
REQ-029 Normal operation SHALL resume on the first rising edge after reset returns to 1.

Verification
REQ-030 Scenario, single call: reset, EA=00, door=0; pulse C_e for 1 cycle. Required: pending=100 after edge 3; dir=UP and {B1,B0}=10 after edge 4.
REQ-031 Scenario, service clear: from REQ-030, set EA=10 and door=1. Required: pending=000 next edge; dir=IDLE; {B1,B0}=10.
REQ-032 Scenario, nearest-first: EA=00; press B_e and C_e together. Required: pending=110, target 01. After EA=01 with door=1: pending=100, target 10, dir=UP.
REQ-033 Scenario, reversal: EA=01, dir=UP, pending=001 (A only). Required: dir=DOWN, target 00. A held C_e press yields one event only.
REQ-034 Scenario, alarm freeze: target 10 with alarm=1; press A_e. Required: pending bit0=1, {B1,B0} stays 10. After alarm=0, re-evaluation per REQ-016..REQ-022.
REQ-035 Scenario, async reset: assert reset=0 between clock edges with pending=111. Required: all outputs 0 immediately, with no clock edge.
